ps2_scancode_decoder: RTL and testbench
=======================================

PS2_SCANCODE_DECODER -- requirements
Module: ps2_scancode_decoder

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4; event FIFO entries, power of two, minimum 2.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1000000; idle cycles allowed between bytes of a multi-byte sequence.
REQ-003 SHALL have port clk, input, 1: single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port byte_valid, input, 1: one-cycle strobe; byte_data holds a received PS/2 byte.
REQ-006 SHALL have port byte_data, input, 8: received scancode byte.
REQ-007 SHALL have port evt_valid, output, 1: FIFO head holds an event.
REQ-008 SHALL have port evt_ready, input, 1: consumer accepts the head event.
REQ-009 SHALL have port evt_code, output, 8: key code of the head event.
REQ-010 SHALL have port evt_ext, output, 1: head event was E0-prefixed.
REQ-011 SHALL have port evt_rel, output, 1: head event is a break (release).
REQ-012 SHALL have port mods, output, 4: {caps_lock, alt, ctrl, shift} live modifier state.
REQ-013 SHALL have port overflow, output, 1: sticky; an event was dropped because the FIFO was full.
REQ-014 SHALL have port seq_abort, output, 1: one-cycle pulse; a partial sequence was discarded.

Function
REQ-015 SHALL implement the parser FSM with states IDLE, GOT_E0, GOT_F0, GOT_E0F0 and PAUSE_SKIP.
REQ-016 In IDLE: E0->GOT_E0; F0->GOT_F0; E1->PAUSE_SKIP with skip count 7; FA, AA, FE, EE, 00 and FF SHALL be ignored; any other byte SHALL push {ext=0, rel=0, code}.
REQ-017 In GOT_E0: F0->GOT_E0F0; E0->stay; any other byte SHALL push {1,0,code} and go to IDLE.
REQ-018 In GOT_F0: any non-prefix byte SHALL push {0,1,code} and go to IDLE; F0->stay; E0 or E1 SHALL pulse seq_abort and be handled as in IDLE.
REQ-019 In GOT_E0F0: any non-prefix byte SHALL push {1,1,code} and go to IDLE; E0, F0 or E1 SHALL pulse seq_abort and be handled as in IDLE.
REQ-020 PAUSE_SKIP SHALL consume 7 bytes without inspecting them, then push {1,0,0x77} and go to IDLE.
REQ-021 Timeout: a counter SHALL clear on every byte_valid; in any state other than IDLE, TIMEOUT_CYCLES cycles without a byte SHALL force IDLE and pulse seq_abort for one cycle.
REQ-022 Latency: an event completed by the byte strobed in cycle N SHALL appear at the FIFO head with evt_valid=1 in cycle N+1 when the FIFO was empty.
REQ-023 The FIFO SHALL be first-word-fall-through; the head pops on the edge where evt_valid&&evt_ready; with evt_valid=0, evt_ready SHALL be ignored.
REQ-024 On a push while full with no pop, the new event SHALL be dropped and overflow set; a push and a pop in the same cycle while full SHALL both succeed.
REQ-025 FIFO pointers SHALL wrap modulo FIFO_DEPTH; occupancy SHALL be a log2(FIFO_DEPTH)+1-bit count.
REQ-026 shift SHALL be 1 while 0x12 or 0x59 (non-ext) is held; ctrl while 0x14 or E0 0x14 is held; alt while 0x11 or E0 0x11 is held. Each key SHALL be tracked separately.
REQ-027 caps_lock SHALL toggle on make of 0x58 only when 0x58 is not already held, so typematic repeats do not toggle it; break of 0x58 SHALL clear the held flag.
REQ-028 mods SHALL update on the same edge the event is generated, even if that event is dropped on overflow.
REQ-029 Bytes arriving back-to-back on consecutive cycles SHALL each be processed.

Reset
REQ-030 While reset=1: FSM=IDLE, FIFO empty, evt_valid=0, evt_code/evt_ext/evt_rel=0, mods=0, overflow=0, seq_abort=0, and the timeout counter and all held flags cleared.
REQ-031 Reset mid-sequence SHALL discard the partial sequence without pulsing seq_abort.

Verification
REQ-032 Bytes 1C, F0 1C with evt_ready=1 -> events {0,0,1C} then {0,1,1C}; each evt_valid appears 1 cycle after its final byte.
REQ-033 Bytes E0 75, E0 F0 75 -> events {1,0,75} then {1,1,75}; mods stay 0.
REQ-034 Bytes 12, then 58 three times, then F0 58, F0 12 -> shift=1 after 12, caps_lock=1 after the first 58 only, shift=0 at the end, caps_lock stays 1.
REQ-035 evt_ready=0, 5 make codes with FIFO_DEPTH=4 -> 4 events retained, 5th dropped, overflow=1; drain yields the first 4 in order.
REQ-036 Byte E0, then no byte for TIMEOUT_CYCLES, then 1C -> one seq_abort pulse, then event {0,0,1C}.
REQ-037 E1 14 77 E1 F0 14 F0 77 -> exactly one event {1,0,77}; FA and AA alone -> no event.

Source files
------------

// File: rtl/ps2_scancode_decoder.sv
// rtl/ps2_scancode_decoder.sv - PS/2 set-2 scancode parser with modifier tracking and event FIFO
module ps2_scancode_decoder #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [7:0] evt_code,
  output logic       evt_ext,
  output logic       evt_rel,
  output logic [3:0] mods,
  output logic       overflow,
  output logic       seq_abort
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  localparam int K_LSHIFT = 0;
  localparam int K_RSHIFT = 1;
  localparam int K_LCTRL  = 2;
  localparam int K_RCTRL  = 3;
  localparam int K_LALT   = 4;
  localparam int K_RALT   = 5;
  localparam int K_CAPS   = 6;

  typedef enum logic [2:0] {IDLE, GOT_E0, GOT_F0, GOT_E0F0, PAUSE_SKIP} state_t;

  state_t          state_q, state_d, idle_state;
  logic [2:0]      skip_q, skip_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            abort_q, abort_d;
  logic            tmo_hit;

  logic            is_e0, is_f0, is_e1, is_prefix, is_ignored;
  logic            ev_push, ev_ext, ev_rel;
  logic [7:0]      ev_code;

  logic [6:0]      keys_q, keys_d;
  logic            caps_q, caps_d;
  logic            key_make;

  logic [9:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]     count_q, count_d;
  logic            ovf_q, ovf_d;
  logic            pop, push_ok;
  logic [9:0]      head;

  assign is_e0      = (byte_data == 8'hE0);
  assign is_f0      = (byte_data == 8'hF0);
  assign is_e1      = (byte_data == 8'hE1);
  assign is_prefix  = is_e0 | is_f0 | is_e1;
  assign is_ignored = (byte_data == 8'hFA) | (byte_data == 8'hAA) | (byte_data == 8'hFE) |
                      (byte_data == 8'hEE) | (byte_data == 8'h00) | (byte_data == 8'hFF);
  assign tmo_hit    = !byte_valid && (state_q != IDLE) && (tmo_q == TMO_LAST);

  // Where a prefix byte leads when seen from IDLE (also used to restart after an abort)
  always_comb begin
    idle_state = IDLE;
    if (is_e0)      idle_state = GOT_E0;
    else if (is_f0) idle_state = GOT_F0;
    else if (is_e1) idle_state = PAUSE_SKIP;
  end

  // Parser state, pause skip count and inter-byte timeout register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      skip_q  <= '0;
      tmo_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
      tmo_q   <= tmo_d;
      abort_q <= abort_d;
    end
  end

  // Next-state: byte arrivals advance the parser, silence outside IDLE runs the timeout
  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    tmo_d   = tmo_q;
    if (byte_valid) begin
      tmo_d = '0;
      unique case (state_q)
        IDLE: begin
          state_d = idle_state;
          skip_d  = 3'd7;
        end
        GOT_E0: begin
          if (is_f0)      state_d = GOT_E0F0;
          else if (is_e0) state_d = GOT_E0;
          else            state_d = IDLE;
        end
        GOT_F0: begin
          if (is_f0) begin
            state_d = GOT_F0;
          end else if (is_prefix) begin
            state_d = idle_state;
            skip_d  = 3'd7;
          end else begin
            state_d = IDLE;
          end
        end
        GOT_E0F0: begin
          if (is_prefix) begin
            state_d = idle_state;
            skip_d  = 3'd7;
          end else begin
            state_d = IDLE;
          end
        end
        PAUSE_SKIP: begin
          skip_d = skip_q - 3'd1;
          if (skip_q == 3'd1) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE) begin
      if (tmo_hit) begin
        state_d = IDLE;
        tmo_d   = '0;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end
  end

  // Outputs of the parser: completed key events and the abort pulse
  always_comb begin
    ev_push = 1'b0;
    ev_ext  = 1'b0;
    ev_rel  = 1'b0;
    ev_code = byte_data;
    abort_d = tmo_hit;
    if (byte_valid) begin
      unique case (state_q)
        IDLE: ev_push = !is_prefix && !is_ignored;
        GOT_E0: begin
          ev_push = !is_f0 && !is_e0;
          ev_ext  = 1'b1;
        end
        GOT_F0: begin
          if (is_e0 || is_e1) abort_d = 1'b1;
          ev_push = !is_prefix;
          ev_rel  = 1'b1;
        end
        GOT_E0F0: begin
          abort_d = is_prefix;
          ev_push = !is_prefix;
          ev_ext  = 1'b1;
          ev_rel  = 1'b1;
        end
        PAUSE_SKIP: begin
          ev_push = (skip_q == 3'd1);
          ev_ext  = 1'b1;
          ev_code = 8'h77;
        end
        default: ev_push = 1'b0;
      endcase
    end
  end

  // Held-key flags and caps lock follow every generated event, dropped or not
  always_comb begin
    keys_d   = keys_q;
    caps_d   = caps_q;
    key_make = !ev_rel;
    if (ev_push) begin
      case ({ev_ext, ev_code})
        9'h012: keys_d[K_LSHIFT] = key_make;
        9'h059: keys_d[K_RSHIFT] = key_make;
        9'h014: keys_d[K_LCTRL]  = key_make;
        9'h114: keys_d[K_RCTRL]  = key_make;
        9'h011: keys_d[K_LALT]   = key_make;
        9'h111: keys_d[K_RALT]   = key_make;
        9'h058: begin
          // Typematic repeats arrive while held; only the first make toggles
          if (key_make && !keys_q[K_CAPS]) caps_d = !caps_q;
          keys_d[K_CAPS] = key_make;
        end
        default: keys_d = keys_q;
      endcase
    end
  end

  // Modifier state register
  always_ff @(posedge clk) begin
    if (reset) begin
      keys_q <= '0;
      caps_q <= 1'b0;
    end else begin
      keys_q <= keys_d;
      caps_q <= caps_d;
    end
  end

  assign pop     = evt_valid && evt_ready;
  // A full FIFO still accepts a push when the head leaves on the same edge
  assign push_ok = ev_push && ((count_q != FULL_CNT) || pop);

  // FIFO pointer, occupancy and sticky overflow next values
  always_comb begin
    wr_d    = wr_q + {{(AW-1){1'b0}}, push_ok};
    rd_d    = rd_q + {{(AW-1){1'b0}}, pop};
    count_d = count_q + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop};
    ovf_d   = ovf_q | (ev_push && !push_ok);
  end

  // FIFO control registers
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // FIFO storage; contents are only visible once counted, so no reset is needed
  always_ff @(posedge clk) begin
    if (!reset && push_ok) mem_q[wr_q] <= {ev_ext, ev_rel, ev_code};
  end

  assign head      = mem_q[rd_q];
  assign evt_valid = (count_q != '0);
  assign evt_ext   = evt_valid ? head[9] : 1'b0;
  assign evt_rel   = evt_valid ? head[8] : 1'b0;
  assign evt_code  = evt_valid ? head[7:0] : 8'h00;
  assign mods      = {caps_q, keys_q[K_LALT] | keys_q[K_RALT],
                      keys_q[K_LCTRL] | keys_q[K_RCTRL], keys_q[K_LSHIFT] | keys_q[K_RSHIFT]};
  assign overflow  = ovf_q;
  assign seq_abort = abort_q;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// tb/tb_ps2_scancode_decoder.sv - scoreboard bench for ps2_scancode_decoder
module tb_ps2_scancode_decoder;

  localparam int DEPTH = 4;
  localparam int TMO   = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       byte_valid = 1'b0;
  logic [7:0] byte_data = 8'h00;
  logic       evt_ready = 1'b1;
  logic       evt_valid, evt_ext, evt_rel, overflow, seq_abort;
  logic [7:0] evt_code;
  logic [3:0] mods;

  always #5 clk = ~clk;

  ps2_scancode_decoder #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .byte_valid(byte_valid), .byte_data(byte_data),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_code(evt_code),
    .evt_ext(evt_ext), .evt_rel(evt_rel), .mods(mods),
    .overflow(overflow), .seq_abort(seq_abort)
  );

  typedef struct packed {logic ext; logic rel; logic [7:0] code;} ev_t;

  typedef struct {
    string       name;
    int          nb;
    logic [63:0] bytes;
    int          ne;
    logic [59:0] evs;
    logic [3:0]  mods;
    int          aborts;
  } vec_t;

  ev_t  exp_q[$];
  ev_t  mon_e;
  vec_t vecs[11];
  int   errors = 0;
  int   checks = 0;
  int   abort_cnt = 0;
  int   a0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && seq_abort) abort_cnt++;
    if (!reset && evt_valid && evt_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: got %h expected none", {evt_ext, evt_rel, evt_code});
      end else begin
        mon_e = exp_q.pop_front();
        check("event", {22'd0, evt_ext, evt_rel, evt_code}, {22'd0, mon_e});
      end
    end
  end

  function automatic vec_t mk(input string n, input int nb, input logic [63:0] by,
                              input int ne, input logic [59:0] ev, input logic [3:0] m, input int ab);
    vec_t v;
    v.name = n; v.nb = nb; v.bytes = by; v.ne = ne; v.evs = ev; v.mods = m; v.aborts = ab;
    return v;
  endfunction

  task automatic drive(input logic [7:0] b);
    @(posedge clk); #1;
    byte_valid = 1'b1;
    byte_data  = b;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      byte_valid = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    byte_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    exp_q.delete();
    reset = 1'b0;
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || evt_valid) && k < 60) begin
      @(negedge clk);
      k++;
    end
    repeat (3) @(negedge clk);
    check({name, "_drain"}, exp_q.size(), 0);
  endtask

  task automatic push_exp(input logic [9:0] v);
    exp_q.push_back(v);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = mk("make_break", 3, 64'h1C_F0_1C, 2, {10'h01C, 10'h11C}, 4'b0000, 0);
    vecs[1]  = mk("ext_make_break", 5, 64'hE0_75_E0_F0_75, 2, {10'h275, 10'h375}, 4'b0000, 0);
    vecs[2]  = mk("shift_caps", 8, 64'h12_58_58_58_F0_58_F0_12, 6,
                  {10'h012, 10'h058, 10'h058, 10'h058, 10'h158, 10'h112}, 4'b1000, 0);
    vecs[3]  = mk("pause", 8, 64'hE1_14_77_E1_F0_14_F0_77, 1, {10'h277}, 4'b0000, 0);
    vecs[4]  = mk("ack_bat", 2, 64'hFA_AA, 0, 60'd0, 4'b0000, 0);
    vecs[5]  = mk("f0_then_e0", 3, 64'hF0_E0_75, 1, {10'h275}, 4'b0000, 1);
    vecs[6]  = mk("ctrl_ralt_rshift", 4, 64'h14_E0_11_59, 3,
                  {10'h014, 10'h211, 10'h059}, 4'b0111, 0);
    vecs[7]  = mk("e0f0_then_f0", 4, 64'hE0_F0_F0_1C, 1, {10'h11C}, 4'b0000, 1);
    vecs[8]  = mk("e0_e0_rctrl", 3, 64'hE0_E0_14, 1, {10'h214}, 4'b0010, 0);
    vecs[9]  = mk("two_shifts", 4, 64'h12_59_F0_12, 3,
                  {10'h012, 10'h059, 10'h112}, 4'b0001, 0);
    vecs[10] = mk("ignored_set", 5, 64'h00_FF_EE_FE_29, 1, {10'h029}, 4'b0000, 0);

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_evt_valid", {31'd0, evt_valid}, 0);
    check("reset_evt_fields", {22'd0, evt_ext, evt_rel, evt_code}, 0);
    check("reset_mods", {28'd0, mods}, 0);
    check("reset_overflow", {31'd0, overflow}, 0);
    check("reset_seq_abort", {31'd0, seq_abort}, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // table-driven sequences, bytes back to back
    for (int v = 0; v < 11; v++) begin
      do_reset();
      a0 = abort_cnt;
      for (int i = 0; i < vecs[v].ne; i++)
        exp_q.push_back(vecs[v].evs[10*(vecs[v].ne-1-i) +: 10]);
      for (int i = 0; i < vecs[v].nb; i++)
        drive(vecs[v].bytes[8*(vecs[v].nb-1-i) +: 8]);
      idle(1);
      drain(vecs[v].name);
      check({vecs[v].name, "_mods"}, {28'd0, mods}, {28'd0, vecs[v].mods});
      check({vecs[v].name, "_aborts"}, abort_cnt - a0, vecs[v].aborts);
    end

    // latency: event visible exactly one cycle after its final byte
    do_reset();
    push_exp(10'h01C);
    drive(8'h1C);
    @(negedge clk);
    check("lat_same_cycle", {31'd0, evt_valid}, 0);
    idle(1);
    @(negedge clk);
    check("lat_next_valid", {31'd0, evt_valid}, 1);
    check("lat_next_code", {24'd0, evt_code}, 32'h1C);
    @(negedge clk);
    check("lat_popped", {31'd0, evt_valid}, 0);
    drain("lat");

    // caps lock toggles on the first make only
    do_reset();
    push_exp(10'h012); push_exp(10'h058); push_exp(10'h058);
    push_exp(10'h058); push_exp(10'h158); push_exp(10'h112);
    drive(8'h12); idle(1); @(negedge clk);
    check("caps_shift_on", {28'd0, mods}, 32'b0001);
    drive(8'h58); idle(1); @(negedge clk);
    check("caps_first_make", {28'd0, mods}, 32'b1001);
    drive(8'h58); drive(8'h58); idle(1); @(negedge clk);
    check("caps_repeat", {28'd0, mods}, 32'b1001);
    drive(8'hF0); drive(8'h58); idle(1); @(negedge clk);
    check("caps_break", {28'd0, mods}, 32'b1001);
    drive(8'hF0); drive(8'h12); idle(1); @(negedge clk);
    check("caps_shift_off", {28'd0, mods}, 32'b1000);
    drain("caps");

    // overflow: fifth event dropped but still updates mods
    do_reset();
    evt_ready = 1'b0;
    push_exp(10'h01C); push_exp(10'h032); push_exp(10'h021); push_exp(10'h023);
    drive(8'h1C); drive(8'h32); drive(8'h21); drive(8'h23);
    idle(2); @(negedge clk);
    check("ovf_before", {31'd0, overflow}, 0);
    check("ovf_full_valid", {31'd0, evt_valid}, 1);
    drive(8'h12); idle(2); @(negedge clk);
    check("ovf_set", {31'd0, overflow}, 1);
    check("ovf_mods", {28'd0, mods}, 32'b0001);
    check("ovf_head", {24'd0, evt_code}, 32'h1C);
    @(posedge clk); #1;
    evt_ready = 1'b1;
    drain("ovf");
    check("ovf_sticky", {31'd0, overflow}, 1);

    // full FIFO: push and pop on the same edge both succeed
    do_reset();
    @(negedge clk);
    check("pp_ovf_cleared", {31'd0, overflow}, 0);
    evt_ready = 1'b0;
    push_exp(10'h01C); push_exp(10'h032); push_exp(10'h021);
    push_exp(10'h023); push_exp(10'h024);
    drive(8'h1C); drive(8'h32); drive(8'h21); drive(8'h23);
    idle(2);
    @(posedge clk); #1;
    byte_valid = 1'b1;
    byte_data  = 8'h24;
    evt_ready  = 1'b1;
    idle(1);
    drain("pp");
    check("pp_no_overflow", {31'd0, overflow}, 0);

    // timeout after an E0 prefix
    do_reset();
    a0 = abort_cnt;
    push_exp(10'h01C);
    drive(8'hE0);
    idle(TMO + 5);
    check("tmo_abort", abort_cnt - a0, 1);
    drive(8'h1C);
    idle(1);
    drain("tmo");
    check("tmo_abort_once", abort_cnt - a0, 1);

    // gap shorter than the timeout keeps the prefix
    do_reset();
    a0 = abort_cnt;
    push_exp(10'h275);
    drive(8'hE0);
    idle(TMO - 3);
    drive(8'h75);
    idle(1);
    drain("tmo_short");
    check("tmo_short_aborts", abort_cnt - a0, 0);

    // no timeout while idle
    do_reset();
    a0 = abort_cnt;
    idle(TMO + 5);
    check("idle_no_abort", abort_cnt - a0, 0);

    // reset mid-sequence discards silently
    do_reset();
    a0 = abort_cnt;
    push_exp(10'h012);
    drive(8'h12);
    drive(8'hE0);
    idle(1);
    @(posedge clk); #1;
    reset = 1'b1;
    byte_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_mid_mods", {28'd0, mods}, 0);
    check("rst_mid_valid", {31'd0, evt_valid}, 0);
    @(posedge clk); #1;
    exp_q.delete();
    reset = 1'b0;
    push_exp(10'h075);
    drive(8'h75);
    idle(1);
    drain("rst_mid");
    check("rst_mid_aborts", abort_cnt - a0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
